// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM-stage data-memory access engine.
package mem_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned BYTES = XLEN / 8;
  localparam int unsigned OFFW  = $clog2(BYTES);

  typedef enum logic [1:0] {MEM_B, MEM_H, MEM_W, MEM_D} mem_size_e;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} mem_state_e;

  // Latched bus request payload, held stable for the whole handshake.
  typedef struct packed {
    logic             write;
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  wdata;
    logic [BYTES-1:0] wstrb;
  } mem_req_t;

  function automatic logic is_misaligned(mem_size_e size, logic [OFFW-1:0] off);
    case (size)
      MEM_H:   return off[0];
      MEM_W:   return |off[1:0];
      MEM_D:   return |off;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [BYTES-1:0] lane_strobe(mem_size_e size, logic [OFFW-1:0] off);
    case (size)
      MEM_B:   return BYTES'(8'h01) << off;
      MEM_H:   return BYTES'(8'h03) << off;
      MEM_W:   return BYTES'(8'h0F) << off;
      default: return '1;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data extraction: shift the addressed lane down, truncate to size, extend.
module load_align
  import mem_pkg::*;
(
  input  logic [XLEN-1:0] i_resp_data,
  input  logic [OFFW-1:0] i_off,
  input  mem_size_e       i_size,
  input  logic            i_unsigned,
  output logic [XLEN-1:0] o_data
);

  logic [XLEN-1:0] w_shifted;

  assign w_shifted = i_resp_data >> {i_off, 3'b000};

  always_comb begin
    o_data = w_shifted;
    case (i_size)
      MEM_B:   o_data = i_unsigned ? XLEN'(w_shifted[7:0])
                                   : {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
      MEM_H:   o_data = i_unsigned ? XLEN'(w_shifted[15:0])
                                   : {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
      MEM_W:   o_data = i_unsigned ? XLEN'(w_shifted[31:0])
                                   : {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
      default: o_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access engine: aligns stores, extracts loads and stalls the pipe
// while a valid/ready data-memory transaction is outstanding.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             mem_read_in,
  input  logic             mem_write_in,
  input  logic [XLEN-1:0]  addr_in,
  input  logic [XLEN-1:0]  wdata_in,
  input  logic [1:0]       size_in,
  input  logic             unsigned_in,
  output logic             stall_out,
  output logic             load_valid_out,
  output logic [XLEN-1:0]  load_data_out,
  output logic             misaligned_out,
  output logic             req_valid,
  input  logic             req_ready,
  output logic             req_write,
  output logic [XLEN-1:0]  req_addr,
  output logic [XLEN-1:0]  req_wdata,
  output logic [BYTES-1:0] req_wstrb,
  input  logic             resp_valid,
  input  logic [XLEN-1:0]  resp_data
);

  mem_state_e      r_state, w_next_state;
  mem_req_t        r_req;
  mem_size_e       r_size;
  logic [OFFW-1:0] r_off;
  logic            r_unsigned;
  logic            r_drop;
  logic [XLEN-1:0] r_load_data;

  mem_size_e       w_size;
  logic [OFFW-1:0] w_off;
  logic            w_access;
  logic            w_write;
  logic            w_misaligned;
  logic            w_accept;
  logic            w_capture;
  logic [XLEN-1:0] w_load_result;

  assign w_size       = mem_size_e'(size_in);
  assign w_off        = addr_in[OFFW-1:0];
  assign w_access     = mem_read_in | mem_write_in;
  assign w_write      = mem_write_in & ~mem_read_in;
  assign w_misaligned = is_misaligned(w_size, w_off);

  load_align u_load_align (
    .i_resp_data (resp_data),
    .i_off       (r_off),
    .i_size      (r_size),
    .i_unsigned  (r_unsigned),
    .o_data      (w_load_result)
  );

  // Next-state and handshake/pulse outputs.
  always_comb begin
    w_next_state   = r_state;
    stall_out      = 1'b0;
    misaligned_out = 1'b0;
    load_valid_out = 1'b0;
    req_valid      = 1'b0;
    w_accept       = 1'b0;
    w_capture      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!reset && w_access) begin
          if (w_misaligned) begin
            misaligned_out = 1'b1;
          end else begin
            stall_out    = 1'b1;
            w_accept     = 1'b1;
            w_next_state = REQ;
          end
        end
      end
      REQ: begin
        req_valid = 1'b1;
        stall_out = ~r_drop & ~flush;
        if (req_ready) w_next_state = WAIT;
      end
      WAIT: begin
        stall_out = ~r_drop & ~flush;
        if (resp_valid) begin
          w_next_state = DONE;
          w_capture    = ~r_req.write & ~r_drop & ~flush;
        end
      end
      DONE: begin
        load_valid_out = ~r_req.write & ~r_drop;
        w_next_state   = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // State, request latches, drop flag and load result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_req       <= '0;
      r_size      <= MEM_B;
      r_off       <= '0;
      r_unsigned  <= 1'b0;
      r_drop      <= 1'b0;
      r_load_data <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == DONE) begin
        r_drop <= 1'b0;
      end else if ((r_state == REQ || r_state == WAIT) && flush) begin
        r_drop <= 1'b1;
      end
      if (w_accept) begin
        r_req.write <= w_write;
        r_req.addr  <= {addr_in[XLEN-1:OFFW], OFFW'(0)};
        r_req.wdata <= w_write ? (wdata_in << {w_off, 3'b000}) : '0;
        r_req.wstrb <= w_write ? lane_strobe(w_size, w_off) : '0;
        r_size      <= w_size;
        r_off       <= w_off;
        r_unsigned  <= unsigned_in;
      end
      if (w_capture) r_load_data <= w_load_result;
    end
  end

  assign req_write     = r_req.write;
  assign req_addr      = r_req.addr;
  assign req_wdata     = r_req.wdata;
  assign req_wstrb     = r_req.wstrb;
  assign load_data_out = r_load_data;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access engine, directly downstream of the EX/MEM pipeline register. It consumes the registered `mem_read`/`mem_write` controls, address, store data and access size, and drives a valid/ready data-memory bus. It aligns store data and byte strobes, extracts and extends load data, and holds a pipeline stall until each access completes.

## Interface
- `XLEN`, 64, data/address width; the bus is XLEN/8 bytes wide.
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `flush`  in  1  kill the current MEM-stage access (exception/redirect)
- `mem_read_in`  in  1  load request from EX/MEM
- `mem_write_in`  in  1  store request from EX/MEM
- `addr_in`  in  XLEN  byte address
- `wdata_in`  in  XLEN  store data, LSB-justified
- `size_in`  in  2  access size: 0=B, 1=H, 2=W, 3=D
- `unsigned_in`  in  1  zero-extend the load when set
- `stall_out`  out  1  freeze the upstream pipeline registers
- `load_valid_out`  out  1  single-cycle pulse; `load_data_out` is valid
- `load_data_out`  out  XLEN  extended load result
- `misaligned_out`  out  1  single-cycle pulse; access rejected
- `req_valid`  out  1  bus request valid
- `req_ready`  in  1  bus request accepted
- `req_write`  out  1  1=store, 0=load
- `req_addr`  out  XLEN  `addr_in` with bits [2:0] cleared
- `req_wdata`  out  XLEN  lane-shifted store data
- `req_wstrb`  out  8  byte enables; all zero for loads
- `resp_valid`  in  1  response/ack; `resp_data` is valid

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - Access is `mem_read_in | mem_write_in`. If both are set, the access is a read and the write is ignored.
  - Misaligned access (H with addr[0]≠0, W with addr[1:0]≠0, D with addr[2:0]≠0): `misaligned_out`=1 this cycle, no bus request, `stall_out`=0, stay in IDLE.
  - Aligned access: latch address, size, sign, write flag, shifted data and strobe; `stall_out`=1; go to REQ.
- REQ:
  - `req_valid`=1 with latched fields, which stay stable until `req_ready`.
  - `req_valid & req_ready` moves to WAIT.
- WAIT: wait for `resp_valid`. Loads capture `resp_data`. Move to DONE.
- DONE:
  - `stall_out`=0.
  - `load_valid_out`=1 for loads, unless the access was dropped.
  - Always return to IDLE.
- Store lane offset is `off=addr[2:0]`.
  - `req_wdata = wdata_in << 8*off`.
  - `req_wstrb`: B=`8'h01<<off`, H=`8'h03<<off`, W=`8'h0F<<off`, D=`8'hFF`.
- Load extraction: `resp_data >> 8*off`, truncated to the access size, then sign- or zero-extended to XLEN. D ignores `unsigned_in`.
- `flush` in IDLE or DONE: no effect on the FSM.
- `flush` in REQ or WAIT:
  - Sets the `drop` flag. The bus transaction still completes; `req_valid` is never withdrawn once asserted.
  - `drop` suppresses `load_valid_out` in DONE. `drop` clears on return to IDLE.
  - `stall_out` is forced to 0 from the flush cycle onward.
  - A new access is not accepted until the FSM returns to IDLE.
- `reset` in any state: next cycle the FSM is in IDLE and `drop`=0.

## Timing
- Reset values: `stall_out`, `load_valid_out`, `misaligned_out`, `req_valid`, `req_write`=0; `req_addr`, `req_wdata`, `req_wstrb`, `load_data_out`=0.
- `stall_out` is combinational from state and inputs: 1 in IDLE with an aligned access, and in REQ and WAIT unless `drop`.
- Minimum latency, with `req_ready` and `resp_valid` both high at first opportunity:
  - Cycle 0: IDLE sees the access.
  - Cycle 1: REQ handshake.
  - Cycle 2: WAIT response.
  - Cycle 3: DONE. 3 stall cycles in total.
- Each `req_ready` or `resp_valid` wait cycle adds one cycle.
- `load_data_out` is registered and holds its value until the next load completes.
- `resp_valid` outside WAIT is ignored.

## Structure
- `mem_pkg` holds:
  - `mem_size_e` (MEM_B/H/W/D).
  - `mem_state_e` (IDLE/REQ/WAIT/DONE).
  - `BYTES = XLEN/8`.
- Sub-module `load_align`: combinational shift, truncate and extend from `resp_data`, offset, size and unsigned, producing the XLEN result.
- `mem_access_unit` holds the FSM, request latches, strobe generation and the `drop` flag.

## Test plan
- Load byte (LB) signed: addr=0x1003, resp_data=0x00000000_80000000 → `req_addr`=0x1000, `req_wstrb`=0, `load_data_out`=0xFFFFFFFF_FFFFFF80, stall high for 3 cycles.
- Store halfword (SH): addr=0x2006, wdata=0xBEEF, `req_ready` delayed 2 cycles → `req_wdata`=0xBEEF0000_00000000, `req_wstrb`=0xC0, fields stable while waiting, 5 stall cycles.
- Load word (LW) at addr=0x3002 → `misaligned_out` pulse, `req_valid` never asserted, `stall_out`=0.
- Load word unsigned (LWU): addr=0x4004, resp_data=0xF0000000_00000000 → `load_data_out`=0x00000000_F0000000.
- `flush` during WAIT of a load → transaction completes, `load_valid_out` stays 0, FSM returns to IDLE.
- `reset` asserted in REQ → next cycle `req_valid`=0 and `stall_out`=0; a subsequent load completes normally.
